// File: rtl/uart_rx_multisampler.sv
// rtl/uart_rx_multisampler.sv - oversampling majority-vote bit sampler for the UART receiver
module uart_rx_multisampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_in,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  rx_sync,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  prescale_err
);

    // Capture counter width and a position width with one guard bit above
    // PRESCALE_W+1 so an underflowing first position reads as negative.
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int XW = PRESCALE_W + 2;
    localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_SAMPLES);
    localparam logic [XW-1:0] HALF_WIN  = XW'(NUM_SAMPLES / 2);
    localparam logic [XW-1:0] WIN_SPAN  = XW'(NUM_SAMPLES - 1);

    logic [XW-1:0]          pre_x;
    logic [XW-1:0]          ec_x;
    logic [XW-1:0]          first_pos;
    logic [XW-1:0]          last_pos;
    logic                   first_neg;
    logic                   legal_now;
    logic                   active;
    logic                   in_window;
    logic                   capture;
    logic                   decide_edge;
    logic [NUM_SAMPLES-1:0] samp_sr;
    logic [CW-1:0]          cap_cnt;
    logic [CW-1:0]          ones;
    logic                   majority;
    logic                   unanimous;

    // RX_in synchroniser; depth 0 passes the line straight through.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_sync = RX_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_ff;

            // Shift the raw line through the synchroniser chain, idle mark on reset.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync_ff <= '1;
                end else begin
                    sync_ff <= (sync_ff << 1) | SYNC_STAGES'(RX_in);
                end
            end

            assign rx_sync = sync_ff[SYNC_STAGES-1];
        end
    endgenerate

    // Sample window centred in the bit: first = ((prescale+1)>>1) - N/2.
    assign pre_x     = {2'b00, prescale};
    assign ec_x      = {2'b00, edge_cnt};
    assign first_pos = ((pre_x + XW'(1)) >> 1) - HALF_WIN;
    assign last_pos  = first_pos + WIN_SPAN;
    assign first_neg = first_pos[XW-1];

    // The whole window must sit strictly before the decision edge.
    assign legal_now = !first_neg && (last_pos < pre_x);

    // Both the registered flag and the live check gate activity, so a
    // prescale change never opens a cycle where capture and decision overlap.
    assign active      = !prescale_err && legal_now;
    assign in_window   = (ec_x >= first_pos) && (ec_x <= last_pos) && (edge_cnt <= prescale);
    assign capture     = dat_samp_en && active && in_window;
    assign decide_edge = dat_samp_en && (edge_cnt == prescale);

    // Count ones in the sample register and detect a unanimous vote.
    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            ones = ones + CW'(samp_sr[i]);
        end
        majority  = (ones > CW'(NUM_SAMPLES / 2));
        unanimous = (samp_sr == '0) || (samp_sr == '1);
    end

    // Capture samples, issue the vote on the decision edge, track prescale legality.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
            prescale_err <= 1'b0;
            samp_sr      <= '0;
            cap_cnt      <= '0;
        end else begin
            prescale_err <= !legal_now;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
            if (!dat_samp_en) begin
                cap_cnt <= '0;
            end else if (decide_edge) begin
                cap_cnt <= '0;
                if (active && (cap_cnt == CNT_FULL)) begin
                    sampled_bit  <= majority;
                    sample_valid <= 1'b1;
                    noise_err    <= !unanimous;
                end
            end else if (capture) begin
                samp_sr <= {samp_sr[NUM_SAMPLES-2:0], rx_sync};
                if (cap_cnt != CNT_FULL) begin
                    cap_cnt <= cap_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_multisampler.sv
// tb/tb_uart_rx_multisampler.sv - randomized self-checking bench for uart_rx_multisampler
module tb_uart_rx_multisampler;

    localparam int W    = 6;
    localparam int MAXC = 16384;
    localparam int NA   = 3;
    localparam int SA   = 2;
    localparam int NB   = 5;
    localparam int SB   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic         en;
    logic [W-1:0] pre;
    logic [W-1:0] ec;

    logic rx_sync_a, sampled_bit_a, sample_valid_a, noise_err_a, prescale_err_a;
    logic rx_sync_b, sampled_bit_b, sample_valid_b, noise_err_b, prescale_err_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pre_i       = 7;
    int strobes_a   = 0;
    int strobes_b   = 0;
    logic [7:0] frame_a, frame_b;
    logic exp_bit_a = 1'b1;
    logic exp_bit_b = 1'b1;

    bit rx_h  [MAXC];
    bit en_h  [MAXC];
    bit rst_h [MAXC];
    int ec_h  [MAXC];
    int pre_h [MAXC];

    uart_rx_multisampler #(.PRESCALE_W(W), .NUM_SAMPLES(NA), .SYNC_STAGES(SA)) dut_a (
        .CLK(clk), .RST(rst), .RX_in(rx), .dat_samp_en(en), .prescale(pre), .edge_cnt(ec),
        .rx_sync(rx_sync_a), .sampled_bit(sampled_bit_a), .sample_valid(sample_valid_a),
        .noise_err(noise_err_a), .prescale_err(prescale_err_a)
    );

    uart_rx_multisampler #(.PRESCALE_W(W), .NUM_SAMPLES(NB), .SYNC_STAGES(SB)) dut_b (
        .CLK(clk), .RST(rst), .RX_in(rx), .dat_samp_en(en), .prescale(pre), .edge_cnt(ec),
        .rx_sync(rx_sync_b), .sampled_bit(sampled_bit_b), .sample_valid(sample_valid_b),
        .noise_err(noise_err_b), .prescale_err(prescale_err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window legality from plain integer arithmetic.
    function automatic bit bad_pre(input int n, input int p);
        int first;
        first = ((p + 1) >> 1) - (n >> 1);
        return !(first >= 0 && first + n - 1 < p);
    endfunction

    function automatic bit is_pos(input int n, input int p, input int e);
        int first;
        first = ((p + 1) >> 1) - (n >> 1);
        return (e >= first) && (e <= first + n - 1) && (e <= p);
    endfunction

    // Line seen at the synchroniser output just after the edge of cycle c.
    function automatic bit sync_after(input int s, input int c);
        if (s == 0) return rx_h[c];
        for (int k = 0; k < s; k++) begin
            if (c - k < 0 || rst_h[c - k]) return 1'b1;
        end
        return rx_h[c - s + 1];
    endfunction

    // Line value the sampler uses at the edge of cycle c.
    function automatic bit rxs_at(input int s, input int c);
        if (s == 0) return rx_h[c];
        if (c == 0) return 1'b1;
        return sync_after(s, c - 1);
    endfunction

    function automatic bit is_active(input int n, input int c);
        bit err_reg;
        err_reg = (c == 0 || rst_h[c - 1]) ? 1'b0 : bad_pre(n, pre_h[c - 1]);
        return !err_reg && !bad_pre(n, pre_h[c]);
    endfunction

    // At a decision cycle, look back through the current bit window for the
    // most recent N sample-position captures and vote on them.
    task automatic model_cycle(input int n, input int s, input int c, inout logic eb,
                               output logic ev, output logic enz);
        int ones;
        int got;
        ev  = 1'b0;
        enz = 1'b0;
        if (rst_h[c]) begin
            eb = 1'b1;
            return;
        end
        if (!(en_h[c] && ec_h[c] == pre_h[c] && is_active(n, c))) return;
        ones = 0;
        got  = 0;
        for (int j = c - 1; j >= 0 && got < n; j--) begin
            if (rst_h[j] || !en_h[j] || ec_h[j] == pre_h[j]) break;
            if (is_active(n, j) && is_pos(n, pre_h[j], ec_h[j])) begin
                got++;
                ones += int'(rxs_at(s, j));
            end
        end
        if (got < n) return;
        ev  = 1'b1;
        eb  = (ones > n / 2);
        enz = (ones != 0 && ones != n);
    endtask

    task automatic tick(input logic r, input logic e, input int ecv, input logic rs);
        logic ev, enz;
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow: observed %0d expected below %0d", cyc, MAXC);
            $fatal(1);
        end
        rx  = r;
        en  = e;
        ec  = W'(ecv);
        pre = W'(pre_i);
        rst = rs;
        rx_h[cyc] = r; en_h[cyc] = e; ec_h[cyc] = ecv; pre_h[cyc] = pre_i; rst_h[cyc] = rs;
        @(posedge clk);
        @(negedge clk);
        model_cycle(NA, SA, cyc, exp_bit_a, ev, enz);
        check($sformatf("a_valid@%0d", cyc), sample_valid_a, ev);
        check($sformatf("a_noise@%0d", cyc), noise_err_a, enz);
        check($sformatf("a_bit@%0d", cyc), sampled_bit_a, exp_bit_a);
        check($sformatf("a_perr@%0d", cyc), prescale_err_a, rs ? 1'b0 : bad_pre(NA, pre_i));
        check($sformatf("a_sync@%0d", cyc), rx_sync_a, sync_after(SA, cyc));
        model_cycle(NB, SB, cyc, exp_bit_b, ev, enz);
        check($sformatf("b_valid@%0d", cyc), sample_valid_b, ev);
        check($sformatf("b_noise@%0d", cyc), noise_err_b, enz);
        check($sformatf("b_bit@%0d", cyc), sampled_bit_b, exp_bit_b);
        check($sformatf("b_perr@%0d", cyc), prescale_err_b, rs ? 1'b0 : bad_pre(NB, pre_i));
        check($sformatf("b_sync@%0d", cyc), rx_sync_b, sync_after(SB, cyc));
        if (sample_valid_a === 1'b1) begin
            strobes_a++;
            frame_a = {sampled_bit_a, frame_a[7:1]};
        end
        if (sample_valid_b === 1'b1) begin
            strobes_b++;
            frame_b = {sampled_bit_b, frame_b[7:1]};
        end
        cyc++;
    endtask

    // One bit period, edge_cnt 0..prescale, line per-edge from rxv.
    task automatic drive_bit(input logic [63:0] rxv, input int en_from, input int en_to);
        for (int e = 0; e <= pre_i; e++) begin
            tick(rxv[e], (e >= en_from) && (e <= en_to), e, 1'b0);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic set_pre(input int p);
        pre_i = p;
        idle(2);
    endtask

    initial begin
        logic [63:0] v;
        logic [7:0]  byte_v;
        int          plist [8];
        plist = '{3, 4, 7, 9, 15, 20, 31, 63};
        rx = 1'b1; en = 1'b0; ec = '0; pre = W'(7); rst = 1'b1;
        frame_a = '0; frame_b = '0;
        @(negedge clk);

        tick(1'b1, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b1);

        // Steady mark then a clean space at prescale 7.
        drive_bit('1, 0, 63);
        strobes_a = 0;
        drive_bit('0, 0, 63);
        check("clean_space_strobes", strobes_a, 1);
        check("clean_space_bit", sampled_bit_a, 1'b0);

        // Single glitch on the middle sample, then a 1,1,0 vote, prescale 15.
        set_pre(15);
        v = '0; v[6] = 1'b1;
        drive_bit(v, 0, 63);
        check("glitch_bit", sampled_bit_a, 1'b0);
        v = '1; v[7] = 1'b0;
        drive_bit(v, 0, 63);
        check("two_of_three_bit", sampled_bit_a, 1'b1);

        // 0xA5 LSB-first at prescale 31.
        set_pre(31);
        drive_bit('1, 0, 63);
        strobes_a = 0; strobes_b = 0;
        byte_v = 8'hA5;
        for (int b = 0; b < 8; b++) drive_bit(byte_v[b] ? '1 : '0, 0, 63);
        check("frame_strobes_a", strobes_a, 8);
        check("frame_strobes_b", strobes_b, 8);
        check("frame_data_a", frame_a, 8'hA5);
        check("frame_data_b", frame_b, 8'hA5);

        // Illegal prescale: nothing decoded, last bit held.
        set_pre(3);
        check("illegal_perr_a", prescale_err_a, 1'b1);
        check("illegal_perr_b", prescale_err_b, 1'b1);
        strobes_a = 0; strobes_b = 0;
        for (int b = 0; b < 4; b++) drive_bit(W'($urandom) == '0 ? '1 : 64'($urandom), 0, 63);
        check("illegal_strobes_a", strobes_a, 0);
        check("illegal_strobes_b", strobes_b, 0);
        check("illegal_hold_a", sampled_bit_a, 1'b1);

        // Enable raised mid-bit: that bit is dropped, the next one decodes.
        set_pre(7);
        strobes_a = 0;
        drive_bit('0, 5, 63);
        check("late_enable_strobes", strobes_a, 0);
        drive_bit('0, 0, 63);
        check("after_late_strobes", strobes_a, 1);

        // Reset in the middle of a bit after a decoded space.
        for (int e = 0; e < 4; e++) tick(1'b0, 1'b1, e, 1'b0);
        tick(1'b0, 1'b1, 4, 1'b1);
        check("midrst_bit", sampled_bit_a, 1'b1);
        check("midrst_sync", rx_sync_a, 1'b1);
        for (int e = 5; e <= 7; e++) tick(1'b0, 1'b0, e, 1'b0);
        strobes_a = 0;
        drive_bit('0, 0, 63);
        check("post_rst_strobes", strobes_a, 1);
        check("post_rst_bit", sampled_bit_a, 1'b0);

        // Randomized traffic: prescale groups, noisy line, partial enables.
        for (int g = 0; g < 15; g++) begin
            set_pre(plist[$urandom_range(0, 7)]);
            for (int b = 0; b < 10; b++) begin
                int noise_pct;
                int ef;
                int et;
                noise_pct = $urandom_range(0, 15);
                v = $urandom_range(0, 1) ? '1 : '0;
                for (int i = 0; i < 64; i++) begin
                    if ($urandom_range(0, 99) < noise_pct) v[i] = ~v[i];
                end
                ef = ($urandom_range(0, 9) == 0) ? $urandom_range(0, pre_i) : 0;
                et = ($urandom_range(0, 9) == 0) ? pre_i - 1 : 63;
                drive_bit(v, ef, et);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
